// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  localparam int unsigned BUS_AW      = 32;
  localparam int unsigned BUS_DW      = 32;
  localparam int unsigned BUS_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Counts unready cycles of an owned transaction; flags when the budget is used up.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two masters sharing one slave bus, with a watchdog
// that aborts transactions no slave answers.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = BUS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic [BUS_DW-1:0] m0_wdata,
  input  logic [BUS_DW-1:0] m1_wdata,
  input  logic              m0_rd,
  input  logic              m1_rd,
  input  logic              m0_wr,
  input  logic              m1_wr,
  output logic [BUS_DW-1:0] m0_rdata,
  output logic [BUS_DW-1:0] m1_rdata,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic              m0_err,
  output logic              m1_err,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [BUS_DW-1:0] bus_rdata,
  input  logic              bus_ready
);

  bus_state_e r_state;
  bus_state_e w_state_next;
  logic       r_prio;
  logic       w_prio_next;
  logic       r_err_m1;
  logic       w_err_m1_next;
  logic       w_req0;
  logic       w_req1;
  logic       w_wd_inc;
  logic       w_wd_clr;
  logic       w_wd_expired;

  assign w_req0   = m0_rd | m0_wr;
  assign w_req1   = m1_rd | m1_wr;
  assign w_wd_clr = ~w_wd_inc;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (w_wd_clr),
    .inc     (w_wd_inc),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ST_IDLE;
      r_prio   <= 1'b0;
      r_err_m1 <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_prio   <= w_prio_next;
      r_err_m1 <= w_err_m1_next;
    end
  end

  // Grant/handover decisions and the combinational owner mux.
  always_comb begin
    w_state_next  = r_state;
    w_prio_next   = r_prio;
    w_err_m1_next = r_err_m1;
    w_wd_inc      = 1'b0;
    bus_addr      = '0;
    bus_wdata     = '0;
    bus_rd        = 1'b0;
    bus_wr        = 1'b0;
    m0_rdata      = '0;
    m1_rdata      = '0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_next = r_prio ? ST_OWN1 : ST_OWN0;
        end else if (w_req0) begin
          w_state_next = ST_OWN0;
        end else if (w_req1) begin
          w_state_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        bus_addr      = m0_addr;
        bus_wdata     = m0_wdata;
        bus_wr        = m0_wr;
        bus_rd        = m0_rd & ~m0_wr;
        m0_rdata      = bus_rdata;
        m0_ready      = bus_ready;
        w_err_m1_next = 1'b0;
        if (!w_req0) begin
          w_state_next = ST_IDLE;
        end else if (bus_ready) begin
          w_prio_next  = 1'b1;
          w_state_next = w_req1 ? ST_OWN1 : ST_OWN0;
        end else if (w_wd_expired) begin
          w_state_next = ST_ERR;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      ST_OWN1: begin
        bus_addr      = m1_addr;
        bus_wdata     = m1_wdata;
        bus_wr        = m1_wr;
        bus_rd        = m1_rd & ~m1_wr;
        m1_rdata      = bus_rdata;
        m1_ready      = bus_ready;
        w_err_m1_next = 1'b1;
        if (!w_req1) begin
          w_state_next = ST_IDLE;
        end else if (bus_ready) begin
          w_prio_next  = 1'b0;
          w_state_next = w_req0 ? ST_OWN0 : ST_OWN1;
        end else if (w_wd_expired) begin
          w_state_next = ST_ERR;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      ST_ERR: begin
        m0_err       = ~r_err_m1;
        m1_err       = r_err_m1;
        w_prio_next  = ~r_prio;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
